// File: rtl/apb_reg_subordinate.sv
// APB subordinate serving a bank of byte-strobed registers, with programmable wait states.
// Define APB_REG_SUB_PROT_CHECK_EN to reject unprivileged writes (prot[0]=0) with subError.
module apb_reg_word #(
  parameter int DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   we,
  input  logic [DataWidth/8-1:0] strb,
  input  logic [DataWidth-1:0]   wdata,
  output logic [DataWidth-1:0]   q
);
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < DataWidth/8; b++)
        if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module apb_reg_subordinate #(
  parameter int                   AddrWidth  = 32,
  parameter int                   DataWidth  = 32,
  parameter int                   NumRegs    = 8,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int                   WaitStates = 1
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           sel,
  input  logic                           enable,
  input  logic                           write,
  input  logic [AddrWidth-1:0]           addr,
  input  logic [DataWidth-1:0]           wData,
  input  logic [DataWidth/8-1:0]         strb,
  input  logic [2:0]                     prot,
  output logic [DataWidth-1:0]           rData,
  output logic                           ready,
  output logic                           subError,
  output logic [NumRegs*DataWidth-1:0]   regsOut
);
  localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic                   write;
    logic                   err;
    logic [IdxW-1:0]        idx;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] strb;
  } req_t;

  state_t                              state, state_nxt;
  logic [3:0]                          wait_cnt;
  req_t                                req;
  logic [DataWidth-1:0]                rdata_q;
  logic [NumRegs-1:0][DataWidth-1:0]   regs;

  logic [AddrWidth-1:0] offset;
  logic                 hit_c;
  logic [IdxW-1:0]      idx_c;
  logic                 prot_err;
  logic                 commit;

  // Decode straight off the bus in SETUP; the result is what gets latched.
  assign offset = addr - BaseAddr;
  assign hit_c  = (addr[1:0] == 2'b00) && (offset < AddrWidth'(4*NumRegs));
  assign idx_c  = offset[IdxW+1:2];

`ifdef APB_REG_SUB_PROT_CHECK_EN
  assign prot_err = write & ~prot[0];
`else
  assign prot_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel && !enable) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (!sel || wait_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      req      <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETUP) begin
        wait_cnt  <= 4'(WaitStates);
        req.write <= write;
        req.err   <= !hit_c || prot_err;
        req.idx   <= idx_c;
        req.wdata <= wData;
        req.strb  <= strb;
        rdata_q   <= (hit_c && !write) ? regs[idx_c] : '0;
      end else if (state == ACCESS && sel && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  assign ready    = (state == ACCESS) && (wait_cnt == '0) && sel;
  assign rData    = ready ? rdata_q : '0;
  assign subError = ready & req.err;
  assign commit   = ready & req.write & ~req.err;

  for (genvar i = 0; i < NumRegs; i++) begin : g_reg
    apb_reg_word #(.DataWidth(DataWidth)) u_word (
      .clk   (clk),
      .nReset(nReset),
      .we    (commit && (req.idx == IdxW'(i))),
      .strb  (req.strb),
      .wdata (req.wdata),
      .q     (regs[i])
    );
  end

  assign regsOut = regs;

  logic unused_ok;
  assign unused_ok = ^{offset, prot};
endmodule

// File: tb/tb_apb_reg_subordinate.sv
// Scoreboard bench: driver pushes expected responses from a byte-level register model,
// a monitor pops and compares whenever ready is high.
module tb_apb_reg_subordinate;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h40;
  localparam int          WS   = 1;
  localparam int          RW   = NR*DW;

  logic            clk, nReset, sel, enable, write, ready, subError;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wData, rData;
  logic [DW/8-1:0] strb;
  logic [2:0]      prot;
  logic [RW-1:0]   regsOut;

  apb_reg_subordinate #(.AddrWidth(AW), .DataWidth(DW), .NumRegs(NR),
                        .BaseAddr(BASE), .WaitStates(WS)) dut (
    .clk(clk), .nReset(nReset), .sel(sel), .enable(enable), .write(write),
    .addr(addr), .wData(wData), .strb(strb), .prot(prot), .rData(rData),
    .ready(ready), .subError(subError), .regsOut(regsOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            rd;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[NR];
  int            checks = 0;
  int            passes = 0;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [RW-1:0] model_flat();
    logic [RW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  // Monitor: every completed transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nReset && ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending transfer");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("subError", RW'(subError), RW'(e.err));
        if (e.rd) chk("rData", RW'(rData), RW'(e.data));
      end
    end
  end

  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW/8-1:0] s, input logic [2:0] p);
    exp_t    e;
    longint  off;
    bit      hit, perr;
    int      i, n;
    bit      got;
    off  = longint'(a) - longint'(BASE);
    hit  = (a % 4 == 0) && off >= 0 && off < 4*NR;
    i    = hit ? int'(off / 4) : 0;
`ifdef APB_REG_SUB_PROT_CHECK_EN
    perr = wr && (p[0] == 1'b0);
`else
    perr = 1'b0;
`endif
    e.rd   = !wr;
    e.err  = !hit || perr;
    e.data = (hit && !wr) ? model[i] : '0;
    if (wr && !e.err)
      for (int b = 0; b < DW/8; b++)
        if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
    sb.push_back(e);

    @(posedge clk); #1;
    sel = 1'b1; enable = 1'b0; write = wr; addr = a; wData = d; strb = s; prot = p;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      enable = 1'b1;
      if (n >= 2) begin
        addr = $urandom; wData = $urandom; strb = 4'($urandom);
      end
      if (ready) got = 1;
    end
    chk("latency", RW'(n), RW'(WS+2));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
  endtask

  task automatic check_regs(input string name);
    chk(name, regsOut, model_flat());
  endtask

  initial begin
    nReset = 1'b0; sel = 0; enable = 0; write = 0; addr = '0; wData = '0; strb = '0; prot = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #7;
    chk("reset_ready", RW'(ready), '0);
    chk("reset_rData", RW'(rData), '0);
    chk("reset_subError", RW'(subError), '0);
    chk("reset_regs", regsOut, '0);
    #10 nReset = 1'b1;

    // Defaults and strobes
    xfer(1, BASE+4, 32'hDEADBEEF, 4'hF, 3'b001);
    xfer(0, BASE+4, '0, 4'h0, 3'b001);
    idle(); check_regs("regs_deadbeef");
    chk("reg1_word", RW'(regsOut[63:32]), RW'(32'hDEADBEEF));
    xfer(1, BASE+4, 32'h11223344, 4'b0101, 3'b001);
    xfer(0, BASE+4, '0, 4'h0, 3'b001);
    idle(); chk("reg1_strobed", RW'(regsOut[63:32]), RW'(32'hDE22BE44));
    xfer(1, BASE+8, 32'hCAFEF00D, 4'h0, 3'b001);
    idle(); check_regs("regs_strb0");

    // Misses, then an in-range access
    xfer(1, BASE+4*NR, 32'hFFFFFFFF, 4'hF, 3'b001);
    xfer(0, BASE+4*NR, '0, 4'h0, 3'b001);
    xfer(1, BASE+2, 32'hFFFFFFFF, 4'hF, 3'b001);
    xfer(0, BASE+2, '0, 4'h0, 3'b001);
    xfer(0, BASE-4, '0, 4'h0, 3'b001);
    xfer(0, BASE+4, '0, 4'h0, 3'b001);
    idle(); check_regs("regs_after_miss");

    // Back-to-back on reg0
    xfer(1, BASE, 32'hA5A5A5A5, 4'hF, 3'b001);
    xfer(0, BASE, '0, 4'h0, 3'b001);
    idle(); check_regs("regs_b2b");

    // Abort: sel dropped during ACCESS
    @(posedge clk); #1;
    sel = 1; enable = 0; write = 1; addr = BASE+12; wData = 32'h55AA55AA; strb = 4'hF; prot = 3'b001;
    @(posedge clk); #1; enable = 1;
    @(posedge clk); #1; sel = 0; enable = 0;
    repeat (3) @(posedge clk);
    #1; check_regs("regs_abort");

    // Protection attribute
    xfer(1, BASE+16, 32'h0BADC0DE, 4'hF, 3'b000);
    xfer(0, BASE+16, '0, 4'h0, 3'b000);
    xfer(1, BASE+20, 32'h600DF00D, 4'hF, 3'b001);
    xfer(0, BASE+20, '0, 4'h0, 3'b000);
    idle(); check_regs("regs_prot");

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 9))
        0:       a = BASE + 4*NR + 4*$urandom_range(0, 3);
        1:       a = BASE + $urandom_range(0, 4*NR-1);
        2:       a = BASE - 4;
        default: a = BASE + 4*$urandom_range(0, NR-1);
      endcase
      xfer(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle(); check_regs("regs_random");
      end
    end
    idle(); check_regs("regs_random_end");

    // Reset mid-ACCESS drops the write
    @(posedge clk); #1;
    sel = 1; enable = 0; write = 1; addr = BASE+8; wData = 32'h12345678; strb = 4'hF; prot = 3'b001;
    @(posedge clk); #1; enable = 1;
    @(posedge clk); #1;
    nReset = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #1;
    chk("midreset_ready", RW'(ready), '0);
    chk("midreset_rData", RW'(rData), '0);
    chk("midreset_subError", RW'(subError), '0);
    check_regs("midreset_regs");
    sel = 0; enable = 0;
    @(posedge clk); #1 nReset = 1'b1;
    repeat (3) idle();
    check_regs("post_reset_regs");
    xfer(0, BASE+8, '0, 4'h0, 3'b001);
    idle();
    repeat (2) @(posedge clk);
    chk("sb_drain", RW'(sb.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
